// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: first bit appears 1 cycle after accept, frames stream back-to-back,
// ser_ready=0 freezes the frame. Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  logic accept;
  logic xfer;

  always_comb begin
    d_ready     = !rst && ((state_q == IDLE) ||
                           ((state_q == SHIFT) && ser_last_q && ser_ready));
    accept      = d_valid && d_ready;
    xfer        = (state_q == SHIFT) && ser_ready;
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif
    // A new word on the last-bit edge takes priority so frames run without a gap.
    if (accept) begin
      state_d     = SHIFT;
      shreg_d     = d;
      cnt_d       = '0;
      ser_out_d   = out_bit(d);
      ser_valid_d = 1'b1;
      ser_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d    = ^d;
`endif
    end else if (xfer) begin
      shreg_d = shift_one(shreg_q);
      if (ser_last_q) begin
        state_d     = IDLE;
        cnt_d       = '0;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
      end else begin
        cnt_d      = cnt_q + CW'(1);
        ser_out_d  = out_bit(shreg_d);
        ser_last_d = (cnt_d == CW'(FRAME - 1));
`ifdef PISO_PARITY_EN
        if (cnt_q == CW'(WIDTH - 1)) ser_out_d = parity_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
`ifdef PISO_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a bit-queue frame model.
module tb_piso_serializer;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, d_valid, ser_ready;
  logic [W-1:0] d;
  logic m_rdy, m_out, m_vld, m_last, m_busy;
  logic l_rdy, l_out, l_vld, l_last, l_busy;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(m_rdy),
    .ser_out(m_out), .ser_valid(m_vld), .ser_last(m_last),
    .ser_ready(ser_ready), .busy(m_busy));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(l_rdy),
    .ser_out(l_out), .ser_valid(l_vld), .ser_last(l_last),
    .ser_ready(ser_ready), .busy(l_busy));

  int total = 0;
  int bad   = 0;
  bit qm[$];
  bit ql[$];
  bit last_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending bits of the frame(s) still to leave the serial port, oldest first.
  task automatic check_inst(input string nm, input bit q[$], input logic rdy, input logic so,
                            input logic vld, input logic last, input logic bsy);
    bit exp_rdy;
    exp_rdy = !rst && (q.size() == 0 || (q.size() == 1 && ser_ready));
    chk({nm, ".d_ready"}, 32'(rdy), 32'(exp_rdy));
    chk({nm, ".ser_valid"}, 32'(vld), 32'(q.size() != 0));
    chk({nm, ".busy"}, 32'(bsy), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({nm, ".ser_out"}, 32'(so), 32'(q[0]));
      chk({nm, ".ser_last"}, 32'(last), 32'(q.size() == 1));
    end else begin
      chk({nm, ".ser_last_idle"}, 32'(last), 32'(0));
      if (last_rst) chk({nm, ".ser_out_rst"}, 32'(so), 32'(0));
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back(w[W-1-i]);
      ql.push_back(w[i]);
    end
`ifdef PISO_PARITY_EN
    qm.push_back(^w);
    ql.push_back(^w);
`endif
  endtask

  task automatic step(input bit r, input bit dv, input logic [W-1:0] dd, input bit sr);
    bit acc;
    rst = r; d_valid = dv; d = dd; ser_ready = sr;
    @(negedge clk);
    check_inst("msb", qm, m_rdy, m_out, m_vld, m_last, m_busy);
    check_inst("lsb", ql, l_rdy, l_out, l_vld, l_last, l_busy);
    acc = dv && !r && (qm.size() == 0 || (qm.size() == 1 && sr));
    @(posedge clk);
    #1;
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (sr && qm.size() != 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) push_frame(dd);
    end
    last_rst = r;
  endtask

  initial begin
    rst = 1'b1; d_valid = 1'b1; d = 4'b1011; ser_ready = 1'b1;
    @(posedge clk);
    #1;
    last_rst = 1'b1;

    // Reset held with a stale valid word, then released idle.
    step(1, 1, 4'b1011, 1);
    step(1, 1, 4'b1011, 1);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);

    // Single word.
    step(0, 1, 4'b1011, 1);
    repeat (5) step(0, 0, 4'b0000, 1);

    // Back-to-back words with valid held until the second is taken.
    step(0, 1, 4'b1011, 1);
    repeat (4) step(0, 1, 4'b0110, 1);
    repeat (6) step(0, 0, 4'b0000, 1);

    // Back-pressure on the second bit.
    step(0, 1, 4'b1011, 1);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 0);
    step(0, 0, 4'b0000, 0);
    repeat (5) step(0, 0, 4'b0000, 1);

    // Reset mid-frame, then a fresh word.
    step(0, 1, 4'b1011, 1);
    step(0, 0, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);
    step(1, 1, 4'b1111, 1);
    step(0, 1, 4'b0001, 1);
    repeat (6) step(0, 0, 4'b0000, 1);

    // Parity-distinguishing word.
    step(0, 1, 4'b0110, 1);
    repeat (6) step(0, 0, 4'b0000, 1);

    // Random traffic with occasional stalls and resets.
    repeat (2000) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
           W'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (8) step(0, 0, 4'b0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Downstream stage of the 4-bit parallel-in/parallel-out register in the shift_regs group.
- Consumes the parallel word q from that register (connected to d here) and shifts it out one bit per cycle on a serial line.
- Valid/ready handshake on the parallel side; ready back-pressure on the serial side.
- Back-to-back words stream with no idle bubble between frames.

Parameters:
- WIDTH, 4, data word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- d  input  WIDTH  parallel word from the upstream PIPO register.
- d_valid  input  1  d holds a word to be serialized.
- d_ready  output  1  block accepts d on this edge (combinational from state).
- ser_out  output  1  serial data bit (registered).
- ser_valid  output  1  ser_out is a valid frame bit (registered).
- ser_last  output  1  ser_out is the final bit of the frame (registered).
- ser_ready  input  1  downstream consumes the current bit on this edge.
- busy  output  1  a frame is in progress (state == SHIFT).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0, ser_last=0, busy=0. d_ready is forced 0 while rst=1.
- Reset mid-frame: the frame is abandoned at the next edge; no partial bits appear after reset. Sampled d_valid is ignored during that cycle.
- Handshakes:
  - Parallel accept = d_valid & d_ready at a rising edge.
  - Serial bit transfer = ser_valid & ser_ready at a rising edge.
- d_ready = (state==IDLE) | (state==SHIFT & ser_last & ser_ready).
- FSM, IDLE:
  - ser_valid=0, d_ready=1.
  - On accept: capture d into the shift register, set cnt=0, go to SHIFT.
  - The first bit is driven on ser_out in the cycle after the accept edge. Latency is 1 cycle.
- FSM, SHIFT:
  - ser_valid=1 and ser_out = the current bit (MSB of shreg if MSB_FIRST, else LSB).
  - On a transfer: shift the register by one toward the output end, zero-fill, cnt++.
  - ser_last=1 while cnt == FRAME-1, where FRAME = WIDTH, or WIDTH+1 with parity.
- Frame end: on a transfer of the last bit:
  - if a word is accepted on the same edge, load it and stay in SHIFT with cnt=0 (no gap);
  - otherwise go to IDLE and clear ser_valid/ser_last the next cycle.
- Stall: ser_ready=0 holds ser_out, ser_valid, ser_last, cnt and shreg unchanged. No bit is lost or duplicated.
- Changes to d or d_valid while busy (other than on the last-bit edge) have no effect. The captured word is immune to upstream changes.
- Counter width is $clog2(WIDTH+1). cnt never exceeds FRAME-1.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - Even parity (XOR of the captured word) is computed at capture.
  - It is sent as one extra bit after the WIDTH data bits. FRAME=WIDTH+1.
  - ser_last is asserted on the parity bit.
- Undefined: no parity logic; FRAME=WIDTH; ser_last is on the final data bit.

Test Plan:
- Reset: hold rst=1 for 2 cycles with d_valid=1 -> ser_valid=0, ser_out=0, busy=0, d_ready=0; after release d_ready=1 and no frame starts from the stale accept.
- Single word, WIDTH=4, MSB_FIRST=1, ser_ready=1, d=4'b1011 pulsed -> ser_out 1,0,1,1 on 4 consecutive cycles starting 1 cycle after accept; ser_last only on the 4th; ser_valid=0 on the 5th.
- Back-to-back: d=4'b1011 then 4'b0110 with d_valid held -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; ser_last on bits 4 and 8; second accept on the bit-4 edge.
- Back-pressure: d=4'b1011, ser_ready=0 for 2 cycles while bit 2 is shown -> ser_out=0 held 3 cycles; frame takes 6 cycles; received sequence is still 1,0,1,1.
- Reset mid-frame after 2 bits of 4'b1011 -> ser_valid=0 next cycle. Then d=4'b0001 serializes as 0,0,0,1. With MSB_FIRST=0 the same word gives 1,0,0,0.
- PISO_PARITY_EN defined, d=4'b1011 -> ser_out 1,0,1,1,1 with ser_last on the 5th bit. d=4'b0110 -> 0,1,1,0,0.
